// File: rtl/pipe_hazard_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctl
//  Purpose  : Control sequencer for a classic 5-stage pipeline. Carries the
//             decoder control groups through the ID/EX, EX/MEM and MEM/WB
//             registers. Detects load-use hazards (stall plus bubble) and
//             resolves jump and taken-branch redirects (flush). Produces the
//             ALU operand forwarding selects and keeps saturating stall and
//             flush event counters.
//  Ports    : CLK, RSTN (async, active low)
//             ID_*        decoder control groups and register fields in ID
//             MEM_Zero    ALU zero flag held in the EX/MEM datapath register
//             CntClr      synchronous clear of both counters
//             EX_Flag / MEM_Flag / WB_Flag / WB_WReg  stage register contents
//             PCWrite, IFIDWrite, IFIDFlush, PCSrcJump, PCSrcBranch
//             ForwardA/B  00 reg file, 10 EX/MEM, 01 MEM/WB
//             StallCnt, FlushCnt  saturating event counters
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             ID_Jump,
  input  logic [3:0]       ID_EXFlag,
  input  logic [2:0]       ID_MEMFlag,
  input  logic [1:0]       ID_WBFlag,
  input  logic [4:0]       ID_Rs,
  input  logic [4:0]       ID_Rt,
  input  logic [4:0]       ID_Rd,
  input  logic             MEM_Zero,
  input  logic             CntClr,
  output logic [3:0]       EX_Flag,
  output logic [2:0]       MEM_Flag,
  output logic [1:0]       WB_Flag,
  output logic [4:0]       WB_WReg,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IFIDFlush,
  output logic             PCSrcJump,
  output logic             PCSrcBranch,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  // Forwarding select encodings
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Control group bit positions
  localparam int EX_REGDST  = 3;
  localparam int MEM_BRANCH = 2;
  localparam int MEM_MEMRD  = 1;
  localparam int WB_REGWR   = 1;

  // Stage registers
  logic [3:0]       idex_ex_q,    idex_ex_d;
  logic [2:0]       idex_mem_q,   idex_mem_d;
  logic [1:0]       idex_wb_q,    idex_wb_d;
  logic [4:0]       idex_rs_q,    idex_rs_d;
  logic [4:0]       idex_rt_q,    idex_rt_d;
  logic [4:0]       idex_rd_q,    idex_rd_d;
  logic [2:0]       exmem_mem_q,  exmem_mem_d;
  logic [1:0]       exmem_wb_q,   exmem_wb_d;
  logic [4:0]       exmem_wreg_q, exmem_wreg_d;
  logic [1:0]       memwb_wb_q,   memwb_wb_d;
  logic [4:0]       memwb_wreg_q, memwb_wreg_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  logic br_taken;
  logic stall;
  logic jump_go;

  // --------------------------------------------------------------------------
  // Hazard detection. The load-use check always compares rt, even for
  // instructions that do not read rt; this may over-stall but never misses.
  // --------------------------------------------------------------------------
  always_comb begin
    br_taken = exmem_mem_q[MEM_BRANCH] & MEM_Zero;
    stall    = idex_mem_q[MEM_MEMRD] & (idex_rt_q != 5'd0) &
               ((idex_rt_q == ID_Rs) | (idex_rt_q == ID_Rt));
    // A jump held by a stall stays in ID and is retried next cycle.
    jump_go  = ID_Jump & ~stall & ~br_taken;
  end

  // --------------------------------------------------------------------------
  // Next-state for the stage chain and counters
  // --------------------------------------------------------------------------
  always_comb begin
    idex_ex_d  = ID_EXFlag;
    idex_mem_d = ID_MEMFlag;
    idex_wb_d  = ID_WBFlag;
    idex_rs_d  = ID_Rs;
    idex_rt_d  = ID_Rt;
    idex_rd_d  = ID_Rd;
    // Bubble clears the whole ID/EX record, so a bubble in EX never matches
    // a forwarding source (register fields are all $0).
    if (br_taken || stall) begin
      idex_ex_d  = '0;
      idex_mem_d = '0;
      idex_wb_d  = '0;
      idex_rs_d  = '0;
      idex_rt_d  = '0;
      idex_rd_d  = '0;
    end

    exmem_mem_d  = idex_mem_q;
    exmem_wb_d   = idex_wb_q;
    if (br_taken) begin
      exmem_mem_d = '0;
      exmem_wb_d  = '0;
    end
    exmem_wreg_d = idex_ex_q[EX_REGDST] ? idex_rd_q : idex_rt_q;

    memwb_wb_d   = exmem_wb_q;
    memwb_wreg_d = exmem_wreg_q;

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (CntClr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (stall && !br_taken && (stall_cnt_q != CNT_MAX)) begin
        stall_cnt_d = stall_cnt_q + 1'b1;
      end
      if ((br_taken || jump_go) && (flush_cnt_q != CNT_MAX)) begin
        flush_cnt_d = flush_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      idex_ex_q    <= '0;
      idex_mem_q   <= '0;
      idex_wb_q    <= '0;
      idex_rs_q    <= '0;
      idex_rt_q    <= '0;
      idex_rd_q    <= '0;
      exmem_mem_q  <= '0;
      exmem_wb_q   <= '0;
      exmem_wreg_q <= '0;
      memwb_wb_q   <= '0;
      memwb_wreg_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      idex_ex_q    <= idex_ex_d;
      idex_mem_q   <= idex_mem_d;
      idex_wb_q    <= idex_wb_d;
      idex_rs_q    <= idex_rs_d;
      idex_rt_q    <= idex_rt_d;
      idex_rd_q    <= idex_rd_d;
      exmem_mem_q  <= exmem_mem_d;
      exmem_wb_q   <= exmem_wb_d;
      exmem_wreg_q <= exmem_wreg_d;
      memwb_wb_q   <= memwb_wb_d;
      memwb_wreg_q <= memwb_wreg_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Forwarding: the younger EX/MEM result wins over MEM/WB.
  // --------------------------------------------------------------------------
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       em_wr,
    input logic [4:0] em_reg,
    input logic       mw_wr,
    input logic [4:0] mw_reg
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (mw_wr && (mw_reg != 5'd0) && (mw_reg == src)) sel = FWD_MEMWB;
    if (em_wr && (em_reg != 5'd0) && (em_reg == src)) sel = FWD_EXMEM;
    return sel;
  endfunction

  always_comb begin
    ForwardA = fwd_sel(idex_rs_q, exmem_wb_q[WB_REGWR], exmem_wreg_q,
                       memwb_wb_q[WB_REGWR], memwb_wreg_q);
    ForwardB = fwd_sel(idex_rt_q, exmem_wb_q[WB_REGWR], exmem_wreg_q,
                       memwb_wb_q[WB_REGWR], memwb_wreg_q);
  end

  // --------------------------------------------------------------------------
  // Sequencing outputs. A taken branch overrides stall and jump. All are
  // gated by RSTN so that the PC and IF/ID stay frozen while in reset even
  // though the ID-stage inputs may be toggling.
  // --------------------------------------------------------------------------
  always_comb begin
    PCWrite     = RSTN & (br_taken | ~stall);
    IFIDWrite   = RSTN & (br_taken | ~stall);
    IFIDFlush   = RSTN & (br_taken | jump_go);
    PCSrcJump   = RSTN & jump_go;
    PCSrcBranch = RSTN & br_taken;
  end

  assign EX_Flag  = idex_ex_q;
  assign MEM_Flag = exmem_mem_q;
  assign WB_Flag  = memwb_wb_q;
  assign WB_WReg  = memwb_wreg_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule
`default_nettype wire
